// File: rtl/vc_test_src_rr_arbiter.sv
// Round-robin val/rdy merge of p_num_reqs test sources with bounded burst ownership.
// Define VC_TEST_SRC_RR_ARBITER_ASSERT_EN to compile in clocked protocol checks.
module vc_test_src_rr_arbiter #(
  parameter int unsigned p_num_reqs  = 4,
  parameter int unsigned p_msg_nbits = 32,
  parameter int unsigned p_max_burst = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [p_num_reqs-1:0]               in_val,
  output logic [p_num_reqs-1:0]               in_rdy,
  input  logic [p_num_reqs*p_msg_nbits-1:0]   in_msg,
  input  logic [p_num_reqs-1:0]               in_done,
  output logic                                out_val,
  input  logic                                out_rdy,
  output logic [p_msg_nbits-1:0]              out_msg,
  output logic [$clog2(p_num_reqs)-1:0]       out_src,
  output logic                                all_done
);

  localparam int unsigned SW = $clog2(p_num_reqs);
  localparam int unsigned CW = $clog2(p_max_burst + 1);

  typedef enum logic [1:0] {IDLE, HOLD, BURST} state_t;

  state_t          state;
  logic [SW-1:0]   owner;
  logic [SW-1:0]   ptr;
  logic [CW-1:0]   burst_cnt;

  logic [SW-1:0]   scan_start;
  logic [SW-1:0]   scan_idx;
  logic            scan_found;
  int unsigned     scan_pos;
  logic [SW-1:0]   grant;
  logic            grant_val;
  logic            cont;
  logic            xfer;
  logic [CW-1:0]   cnt_next;
  logic            burst_end;

  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] x);
    return (32'(x) == p_num_reqs - 1) ? '0 : x + SW'(1);
  endfunction

  // Rotating priority scan; a burst that loses its owner restarts just past the owner.
  always_comb begin
    scan_start = (state == BURST) ? wrap_inc(owner) : ptr;
    scan_found = 1'b0;
    scan_idx   = '0;
    scan_pos   = 0;
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      scan_pos = 32'(scan_start) + i;
      if (scan_pos >= p_num_reqs) scan_pos = scan_pos - p_num_reqs;
      if (!scan_found && in_val[SW'(scan_pos)]) begin
        scan_found = 1'b1;
        scan_idx   = SW'(scan_pos);
      end
    end
  end

  // HOLD pins the grant; BURST keeps the owner while it stays valid.
  always_comb begin
    grant     = scan_idx;
    grant_val = scan_found;
    cont      = 1'b0;
    case (state)
      HOLD: begin
        grant     = owner;
        grant_val = in_val[owner];
      end
      BURST: begin
        if (in_val[owner]) begin
          grant     = owner;
          grant_val = 1'b1;
          cont      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign out_val   = reset & grant_val;
  assign xfer      = out_val & out_rdy;
  assign out_src   = grant;
  assign out_msg   = in_msg[32'(grant)*p_msg_nbits +: p_msg_nbits];
  assign cnt_next  = cont ? burst_cnt + CW'(1) : CW'(1);
  assign burst_end = (cnt_next == CW'(p_max_burst));

  always_comb begin
    in_rdy = '0;
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      in_rdy[i] = xfer && (grant == SW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
      all_done  <= 1'b0;
    end else begin
      all_done <= &in_done;
      if (xfer) begin
        burst_cnt <= cnt_next;
        if (burst_end) begin
          state <= IDLE;
          ptr   <= wrap_inc(grant);
        end else begin
          state <= BURST;
          owner <= grant;
        end
      end else if (out_val) begin
        // Stalled new grant: lock it so out_msg cannot change before acceptance.
        if (!cont && state != HOLD) begin
          state <= HOLD;
          owner <= grant;
        end
      end else if (state == BURST) begin
        state     <= IDLE;
        ptr       <= wrap_inc(owner);
        burst_cnt <= '0;
      end
    end
  end

`ifdef VC_TEST_SRC_RR_ARBITER_ASSERT_EN
  logic [p_msg_nbits-1:0] prev_msg;

  always_ff @(posedge clk) prev_msg <= out_msg;

  always_ff @(posedge clk) begin
    if (reset) begin
      if (!$onehot0(in_rdy)) begin
        $error("vc_test_src_rr_arbiter: in_rdy not one-hot0 (%b)", in_rdy);
        $finish;
      end
      if (state == HOLD && (!in_val[owner] || out_msg != prev_msg)) begin
        $error("vc_test_src_rr_arbiter: held source %0d dropped val or changed msg", owner);
        $finish;
      end
      if ($isunknown({out_val, out_rdy, in_val})) begin
        $error("vc_test_src_rr_arbiter: X on out_val/out_rdy/in_val");
        $finish;
      end
      if (burst_cnt > CW'(p_max_burst)) begin
        $error("vc_test_src_rr_arbiter: burst_cnt %0d exceeds max", burst_cnt);
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vc_test_src_rr_arbiter.sv
// Self-checking bench for vc_test_src_rr_arbiter: directed scenarios plus randomized traffic vs a model.
module tb_vc_test_src_rr_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int B = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   in_val;
  logic [N-1:0]   in_rdy;
  logic [N*W-1:0] in_msg;
  logic [N-1:0]   in_done;
  logic           out_val;
  logic           out_rdy;
  logic [W-1:0]   out_msg;
  logic [1:0]     out_src;
  logic           all_done;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: lock = stalled grant awaiting acceptance, bown/blen = current burst.
  int m_ptr, m_lock, m_bown, m_blen;

  vc_test_src_rr_arbiter #(.p_num_reqs(N), .p_msg_nbits(W), .p_max_burst(B)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .in_done(in_done), .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
    .out_src(out_src), .all_done(all_done)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_val = '0; out_rdy = 1'b0; in_done = '0; in_msg = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic model_predict(output bit v, output int g, output bit c);
    int start;
    v = 0; g = 0; c = 0;
    if (m_lock >= 0) begin
      v = in_val[m_lock]; g = m_lock;
    end else if (m_bown >= 0 && in_val[m_bown]) begin
      v = 1; g = m_bown; c = 1;
    end else begin
      start = (m_bown >= 0) ? (m_bown + 1) % N : m_ptr;
      for (int k = 0; k < N; k++) begin
        if (!v && in_val[(start + k) % N]) begin
          v = 1; g = (start + k) % N;
        end
      end
    end
  endtask

  task automatic model_update(input bit v, input int g, input bit c);
    if (!reset) begin
      m_ptr = 0; m_lock = -1; m_bown = -1; m_blen = 0;
    end else if (v && out_rdy) begin
      m_blen = c ? m_blen + 1 : 1;
      m_lock = -1;
      if (m_blen == B) begin m_bown = -1; m_ptr = (g + 1) % N; end
      else m_bown = g;
    end else if (v) begin
      if (!c) begin m_lock = g; m_bown = -1; end
    end else if (m_bown >= 0) begin
      m_ptr = (m_bown + 1) % N; m_bown = -1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; in_val = 4'hF; out_rdy = 1'b1; in_done = 4'hF;
    #1;
    n_total++; if (out_val !== 1'b0) $display("FAIL reset_out_val got=%b exp=0", out_val); else n_pass++;
    n_total++; if (in_rdy !== 4'b0) $display("FAIL reset_in_rdy got=%b exp=0000", in_rdy); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (all_done !== 1'b0) $display("FAIL reset_all_done got=%b exp=0", all_done); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (out_val !== 1'b1 || out_src !== 2'd0)
      $display("FAIL reset_first_grant got val=%b src=%0d exp val=1 src=0", out_val, out_src); else n_pass++;
  endtask

  task automatic test_single_source();
    logic [W-1:0] m;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m = W'(32'hA + k);
      in_val = 4'b0100; in_msg[2*W +: W] = m; out_rdy = 1'b1;
      #1;
      n_total++; if (out_val !== 1'b1 || out_src !== 2'd2 || out_msg !== m || in_rdy !== 4'b0100)
        $display("FAIL single_src k=%0d got val=%b src=%0d msg=%h rdy=%b exp 1/2/%h/0100",
                 k, out_val, out_src, out_msg, in_rdy, m);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    int es;
    do_reset();
    for (int i = 0; i < N; i++) in_msg[i*W +: W] = W'(32'h100 + i);
    for (int c = 0; c < 4 * B + 2; c++) begin
      @(negedge clk);
      in_val = 4'hF; out_rdy = 1'b1;
      #1;
      es = (c / B) % N;
      n_total++; if (out_val !== 1'b1 || out_src !== 2'(es) || in_rdy !== 4'(1 << es))
        $display("FAIL round_robin c=%0d got val=%b src=%0d rdy=%b exp src=%0d", c, out_val, out_src, in_rdy, es);
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_val = (c == 0) ? 4'b0010 : 4'b0011;
      in_msg[1*W +: W] = 32'h55; in_msg[0*W +: W] = 32'h99;
      out_rdy = (c == 3);
      #1;
      n_total++; if (out_val !== 1'b1 || out_src !== 2'd1 || out_msg !== 32'h55 ||
                     in_rdy !== ((c == 3) ? 4'b0010 : 4'b0000))
        $display("FAIL hold c=%0d got val=%b src=%0d msg=%h rdy=%b exp src=1 msg=55", c, out_val, out_src, out_msg, in_rdy);
      else n_pass++;
    end
    @(negedge clk);
    in_val = 4'b0001; out_rdy = 1'b1;
    #1;
    n_total++; if (out_src !== 2'd0 || in_rdy !== 4'b0001 || out_msg !== 32'h99)
      $display("FAIL hold_next got src=%0d rdy=%b msg=%h exp src=0 rdy=0001 msg=99", out_src, in_rdy, out_msg);
    else n_pass++;
  endtask

  task automatic test_burst_drop();
    do_reset();
    @(negedge clk);
    in_val = 4'b1000; in_msg[3*W +: W] = 32'h33; out_rdy = 1'b1;
    #1;
    n_total++; if (out_src !== 2'd3 || in_rdy !== 4'b1000)
      $display("FAIL burst_first got src=%0d rdy=%b exp src=3 rdy=1000", out_src, in_rdy); else n_pass++;
    @(negedge clk);
    in_val = 4'b0001; in_msg[0*W +: W] = 32'h44;
    #1;
    n_total++; if (out_val !== 1'b1 || out_src !== 2'd0 || in_rdy !== 4'b0001 || out_msg !== 32'h44)
      $display("FAIL burst_fallback got val=%b src=%0d rdy=%b msg=%h exp 1/0/0001/44", out_val, out_src, in_rdy, out_msg);
    else n_pass++;
    @(negedge clk);
    in_val = 4'b0000;
    #1;
    n_total++; if (out_val !== 1'b0 || in_rdy !== 4'b0)
      $display("FAIL burst_idle got val=%b rdy=%b exp 0/0000", out_val, in_rdy); else n_pass++;
    @(negedge clk);
    in_val = 4'b0011;
    #1;
    n_total++; if (out_src !== 2'd1)
      $display("FAIL burst_ptr got src=%0d exp 1", out_src); else n_pass++;
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    @(negedge clk);
    in_val = 4'b0100; in_msg[2*W +: W] = 32'h77; out_rdy = 1'b0;
    @(negedge clk); #1;
    n_total++; if (out_src !== 2'd2 || out_val !== 1'b1)
      $display("FAIL midhold_pre got src=%0d val=%b exp 2/1", out_src, out_val); else n_pass++;
    reset = 1'b0; out_rdy = 1'b1;
    #1;
    n_total++; if (out_val !== 1'b0 || in_rdy !== 4'b0)
      $display("FAIL midhold_rst got val=%b rdy=%b exp 0/0000", out_val, in_rdy); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (out_val !== 1'b0 || in_rdy !== 4'b0)
      $display("FAIL midhold_rst2 got val=%b rdy=%b exp 0/0000", out_val, in_rdy); else n_pass++;
    reset = 1'b1; in_val = 4'b0101;
    #1;
    n_total++; if (out_src !== 2'd0 || in_rdy !== 4'b0001)
      $display("FAIL midhold_restart got src=%0d rdy=%b exp 0/0001", out_src, in_rdy); else n_pass++;
  endtask

  task automatic test_all_done();
    do_reset();
    @(negedge clk);
    in_done = 4'b1111;
    #1;
    n_total++; if (all_done !== 1'b0) $display("FAIL done_t got=%b exp=0", all_done); else n_pass++;
    @(negedge clk);
    in_done = 4'b1110;
    #1;
    n_total++; if (all_done !== 1'b1) $display("FAIL done_t1 got=%b exp=1", all_done); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (all_done !== 1'b0) $display("FAIL done_partial got=%b exp=0", all_done); else n_pass++;
  endtask

  task automatic test_random();
    bit pv, pc, exp_val, exp_done;
    int pg;
    logic [N-1:0] exp_rdy;
    do_reset();
    m_ptr = 0; m_lock = -1; m_bown = -1; m_blen = 0;
    exp_done = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < N; i++) begin
        if (!(reset && i == m_lock)) begin
          in_val[i] = ($urandom_range(0, 99) < 45);
          in_msg[i*W +: W] = $urandom;
        end
      end
      out_rdy = ($urandom_range(0, 3) != 0);
      in_done = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      #1;
      model_predict(pv, pg, pc);
      exp_val = reset && pv;
      exp_rdy = (exp_val && out_rdy) ? 4'(1 << pg) : 4'b0;
      n_total++; if (out_val !== exp_val)
        $display("FAIL rand_val c=%0d got=%b exp=%b", c, out_val, exp_val); else n_pass++;
      n_total++; if (in_rdy !== exp_rdy)
        $display("FAIL rand_rdy c=%0d got=%b exp=%b", c, in_rdy, exp_rdy); else n_pass++;
      n_total++; if (all_done !== exp_done)
        $display("FAIL rand_done c=%0d got=%b exp=%b", c, all_done, exp_done); else n_pass++;
      if (exp_val) begin
        n_total++; if (out_src !== 2'(pg) || out_msg !== in_msg[pg*W +: W])
          $display("FAIL rand_grant c=%0d got src=%0d msg=%h exp src=%0d msg=%h",
                   c, out_src, out_msg, pg, in_msg[pg*W +: W]);
        else n_pass++;
      end
      exp_done = reset && (&in_done);
      model_update(pv, pg, pc);
    end
  endtask

  initial begin
    reset = 1'b0; in_val = '0; out_rdy = 1'b0; in_done = '0; in_msg = '0;
    test_reset();
    test_single_source();
    test_round_robin();
    test_hold();
    test_burst_drop();
    test_reset_mid_hold();
    test_all_done();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
